// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch PC, credit-limited memory requests and decode queue
// Define IFQ_BYPASS_EN to forward a live response straight to the outputs when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  output logic                   o_imem_req,
  output logic [ADDR_W-1:0]      o_imem_addr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rvalid,
  input  logic [DATA_W-1:0]      i_imem_rdata,
  input  logic                   i_redirect,
  input  logic [ADDR_W-1:0]      i_redirect_pc,
  output logic                   o_inst_valid,
  output logic [DATA_W-1:0]      o_inst,
  output logic [ADDR_W-1:0]      o_inst_pc,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned       PTR_W     = $clog2(DEPTH);
  localparam int unsigned       CNT_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [CNT_W-1:0] live;
  logic [CNT_W:0]   occupancy;
  logic             grant, rsp_live, head_valid, bypass, bypass_take, push, pop;

  // Credit counts queued entries plus live in-flight responses so every live response has a slot.
  assign live        = outstanding_q - discard_q;
  assign occupancy   = {1'b0, count_q} + {1'b0, live};
  assign o_imem_req  = i_start & ~i_redirect & (occupancy < DEPTH_OCC) & (outstanding_q < DEPTH_CNT);
  assign o_imem_addr = fetch_pc_q;
  assign grant       = o_imem_req & i_imem_gnt;
  assign rsp_live    = i_imem_rvalid & (discard_q == '0) & ~i_redirect;
  assign head_valid  = (count_q != '0);
  assign o_count     = count_q;

`ifdef IFQ_BYPASS_EN
  assign bypass      = rsp_live & ~head_valid;
  assign bypass_take = bypass & i_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = rsp_live & ~bypass_take;
  assign pop  = head_valid & i_ready & ~i_redirect;

  always_comb begin
    o_inst_valid = 1'b0;
    o_inst       = '0;
    o_inst_pc    = '0;
    if (head_valid) begin
      o_inst_valid = 1'b1;
      o_inst       = inst_mem_q[rd_ptr_q];
      o_inst_pc    = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      o_inst_valid = 1'b1;
      o_inst       = i_imem_rdata;
      o_inst_pc    = rsp_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(i_imem_rvalid);
    discard_d     = discard_q;
    if (i_redirect) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      fetch_pc_d    = i_redirect_pc;
      rsp_pc_d      = i_redirect_pc;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      outstanding_d = outstanding_q - CNT_W'(i_imem_rvalid);
      discard_d     = outstanding_q - CNT_W'(i_imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_live) rsp_pc_d = rsp_pc_q + STEP;
      if (i_imem_rvalid && discard_q != '0) discard_d = discard_q - CNT_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= i_imem_rdata;
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with an in-order latency memory model
module tb_inst_fetch_queue;

  logic        clk, rst_n, start, imem_req, imem_gnt, imem_rvalid;
  logic        redirect, inst_valid, ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
  typedef struct {int due; logic [31:0] addr;} mreq_t;
  exp_t  exp_q[$];
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  inst_fetch_queue dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_ready(ready), .o_count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, inst: pc ^ 32'hA5A5_0000});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory: responds in order, lat cycles after the grant cycle, data = addr ^ 0xA5A5_0000.
  logic        s_grant, s_rsp;
  logic [31:0] s_addr;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      s_grant = imem_req & imem_gnt;
      s_addr  = imem_addr;
      s_rsp   = imem_rvalid;
      @(posedge clk);
      if (!rst_n) mq.delete();
      else begin
        if (s_rsp && mq.size() > 0) void'(mq.pop_front());
        if (s_grant) mq.push_back('{due: cyc + lat, addr: s_addr});
      end
      cyc++;
      #1;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].addr ^ 32'hA5A5_0000;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Monitor: a handshake outside a redirect cycle consumes the next expected instruction.
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (inst_valid) begin
          if (ready && !redirect) begin
            if (exp_q.size() == 0) check("unexpected_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              check("sb_pc", inst_pc, e.pc);
              check("sb_inst", inst, e.inst);
            end
          end
        end else begin
          check("idle_inst_zero", inst, 0);
          check("idle_pc_zero", inst_pc, 0);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_gnt = 1'b0; ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_count", count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) next_cycle();
    @(negedge clk);
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_count", count, 0);
    exp_q.delete();
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Basic stream
    do_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) exp_push(i);
    start = 1'b1; imem_gnt = 1'b1; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stream_req", imem_req, 1);
      check("stream_addr", imem_addr, i);
      if (i >= 2) check("stream_valid", inst_valid, 1);
      next_cycle();
    end
    start = 1'b0;
    drain(5);

    // Backpressure
    do_reset();
    lat = 1;
    start = 1'b1; imem_gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 4) check("bp_req_low", imem_req, 0);
      if (i >= 5) begin
        check("bp_count_sat", count, 4);
        check("bp_addr", imem_addr, 4);
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) exp_push(i);
    start = 1'b0; ready = 1'b1;
    drain(6);

    // Grant stall at address 5
    do_reset();
    lat = 1;
    for (int i = 0; i < 7; i++) exp_push(i);
    start = 1'b1; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_gnt = !(i >= 5 && i < 8);
      @(negedge clk);
      if (i >= 5 && i <= 8) check("stall_addr_hold", imem_addr, 5);
      if (i >= 5 && i <= 8) check("stall_req", imem_req, 1);
      if (i == 9) check("stall_resume_addr", imem_addr, 6);
      next_cycle();
    end
    start = 1'b0;
    drain(5);

    // Redirect with two in flight, 3-cycle memory
    do_reset();
    lat = 3;
    exp_push(32'h40); exp_push(32'h41);
    imem_gnt = 1'b1; ready = 1'b1; redirect_pc = 32'h40;
    for (int i = 0; i < 6; i++) begin
      redirect = (i == 2);
      start = (i < 5);
      @(negedge clk);
      if (i == 2) check("redir_no_req", imem_req, 0);
      if (i == 3) begin
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_count", count, 0);
      end
      if (i == 4) check("redir_addr_next", imem_addr, 32'h41);
      next_cycle();
    end
    redirect = 1'b0; start = 1'b0;
    drain(8);

    // Redirect + response + pop in the same cycle
    do_reset();
    lat = 1;
    exp_push(32'h80);
    imem_gnt = 1'b1; redirect_pc = 32'h80;
    for (int i = 0; i < 6; i++) begin
      start = (i < 3) || (i == 4);
      ready = (i >= 3);
      redirect = (i == 3);
      @(negedge clk);
      if (i == 3) begin
        check("simul_count_before", count, 2);
        check("simul_valid_before", inst_valid, 1);
      end
      if (i == 4) begin
        check("simul_count_after", count, 0);
        check("simul_valid_after", inst_valid, 0);
        check("simul_req", imem_req, 1);
        check("simul_addr", imem_addr, 32'h80);
      end
      next_cycle();
    end
    start = 1'b0; redirect = 1'b0;
    drain(5);

    // Asynchronous reset mid-stream with three queued
    do_reset();
    lat = 1;
    imem_gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i < 3);
      @(negedge clk);
      if (i == 4) begin
        check("mid_count", count, 3);
        check("mid_head_pc", inst_pc, 0);
        check("mid_head_inst", inst, 32'hA5A5_0000);
      end
      if (i < 4) next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_valid", inst_valid, 0);
    check("async_inst", inst, 0);
    check("async_pc", inst_pc, 0);
    check("async_addr", imem_addr, 0);
    check("async_req", imem_req, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_push(0); exp_push(1);
    start = 1'b1; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("restart_req", imem_req, 1);
      check("restart_addr", imem_addr, i);
      next_cycle();
    end
    start = 1'b0;
    drain(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end: owns the fetch PC, issues in-order requests to instruction memory, and buffers returned instructions in a DEPTH-entry queue ahead of `inst_dec`. It decouples fetch from decode with a valid/ready handshake, and supports flush-and-redirect for taken branches and jumps. Stale in-flight responses are discarded. It replaces the direct `i_inst` input and `pc + 1` logic in the CPU top.

## Interface
- `DATA_W`, 32, instruction width.
- `ADDR_W`, 32, PC / instruction-memory address width.
- `DEPTH`, 4, queue entries; power of two, ≥ 2.
- `PC_STEP`, 1, PC increment per instruction (word addressing).
- `RESET_PC`, 0, fetch PC after reset.

Ports:
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  fetch enable; no new requests while low.
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  ADDR_W  fetch address; equals fetch PC.
- `i_imem_gnt`  in  1  request accepted this cycle.
- `i_imem_rvalid`  in  1  response valid; responses arrive in order, ≥ 1 cycle after grant.
- `i_imem_rdata`  in  DATA_W  response instruction.
- `i_redirect`  in  1  flush and restart fetch.
- `i_redirect_pc`  in  ADDR_W  new fetch PC.
- `o_inst_valid`  out  1  head entry valid.
- `o_inst`  out  DATA_W  head instruction; 0 when `o_inst_valid` = 0.
- `o_inst_pc`  out  ADDR_W  PC of head instruction; 0 when invalid.
- `i_ready`  in  1  decode consumes head when `o_inst_valid & i_ready`.
- `o_count`  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- State:
  - `fetch_pc`.
  - `rsp_pc`: PC of the next live response.
  - FIFO of DEPTH × DATA_W instructions plus their PCs.
  - `outstanding`: granted requests without a response.
  - `discard`: stale responses still to be dropped.
  - All counters are $clog2(DEPTH)+1 bits.
- `live` = `outstanding − discard`.
- Request: `o_imem_req = i_start & !i_redirect & (count + live < DEPTH) & (outstanding < DEPTH)`.
- Grant (`o_imem_req & i_imem_gnt`): `fetch_pc += PC_STEP` (wraps modulo 2^ADDR_W); `outstanding++`.
- `o_imem_addr` stays stable while `o_imem_req` is high and ungranted.
- Response when `discard > 0`:
  - Dropped; `discard--`, `outstanding--`.
- Response when `discard = 0`:
  - Pushed with PC `rsp_pc`; `rsp_pc += PC_STEP`; `outstanding--`.
  - The credit rule guarantees space, so the queue never overflows.
- Pop: the head is removed on `o_inst_valid & i_ready`. Push and pop may occur in the same cycle; count is unchanged.
- Redirect (highest priority):
  - Queue cleared (`count` ← 0); any pop that cycle is ignored.
  - `fetch_pc` ← `i_redirect_pc`; `rsp_pc` ← `i_redirect_pc`.
  - `discard` ← `outstanding − i_imem_rvalid`; `outstanding` ← `outstanding − i_imem_rvalid`.
  - A response arriving in the redirect cycle is dropped. No request is issued in the redirect cycle.
- `i_start` low does not clear the queue or stop response collection.

## Timing
- Reset values:
  - `fetch_pc` = `rsp_pc` = `RESET_PC`.
  - `o_imem_req` = 0, `o_imem_addr` = `RESET_PC`.
  - `o_inst_valid` = 0, `o_inst` = 0, `o_inst_pc` = 0, `o_count` = 0.
  - Counters = 0.
- Reset asserted mid-operation clears everything immediately. Responses to pre-reset requests are the memory's responsibility: it must also be reset.
- First request: the cycle after `i_start` is sampled high out of reset, or combinationally if `i_start` is already high.
- Response-to-output latency is 1 cycle: `o_inst_valid` rises the cycle after a pushed `i_imem_rvalid`.
- Redirect-to-new-request latency is 1 cycle: the request for `i_redirect_pc` appears the cycle after `i_redirect`.
- Throughput: 1 instruction/cycle with a 1-cycle memory, `i_imem_gnt` = 1 and `i_ready` = 1.

## Configuration
- `IFQ_BYPASS_EN` defined: when the queue is empty and a live response arrives, it drives `o_inst` / `o_inst_pc` / `o_inst_valid` combinationally in the same cycle.
  - If `i_ready` = 1 that cycle, it is consumed and not stored.
  - Otherwise it is stored as usual.
  - Latency becomes 0 cycles.
- `IFQ_BYPASS_EN` undefined: latency is 1 cycle as above.

## Test plan
- Basic stream: reset, `i_start` = 1, `i_imem_gnt` = 1, 1-cycle memory returning data = addr ^ 0xA5A5_0000, `i_ready` = 1 → addresses 0, 1, 2, … each cycle; `o_inst_pc` 0, 1, 2, … with matching data, one per cycle after the 2-cycle startup.
- Backpressure: `DEPTH` = 4, `i_ready` = 0 → `o_imem_req` drops once count + live = 4, `o_count` saturates at 4; then `i_ready` = 1 → PCs 0–3 in order, no loss or duplication.
- Grant stall: `i_imem_gnt` = 0 for 3 cycles at address 5 → `o_imem_addr` held at 5, `fetch_pc` not advanced; resumes at 6 after grant.
- Redirect with 2 in flight (3-cycle memory), `i_redirect_pc` = 0x40 → both stale responses dropped; next `o_inst_pc` = 0x40; next request at 0x40 one cycle after redirect.
- Simultaneous redirect + `i_imem_rvalid` + pop → queue empty next cycle, response dropped, `outstanding` decremented, no underflow.
- Reset mid-stream with count = 3 → all outputs return to reset values asynchronously; fetch restarts at `RESET_PC`.
